// File: rtl/choose_ref_node_control_pkg.sv
// Shared stage-4 definitions: the choose-ref-node FSM state encoding and
// the default prompt auto-advance interval.
package choose_ref_node_control_pkg;

   // 3-bit state encoding; IDLE must stay at zero so reset lands there.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RST     = 3'd1,
      ST_CHOOSE  = 3'd2,
      ST_REFNODE = 3'd3,
      ST_LOAD    = 3'd4,
      ST_JUDGE   = 3'd5,
      ST_INVALID = 3'd6,
      ST_DONE    = 3'd7
   } state_t;

   // Prompt auto-advance interval: 1 s at 50 MHz.
   localparam int DEFAULT_HOLD_CYCLES = 50_000_000;

endpackage

// File: rtl/choose_ref_node_control_key_edge_detect.sv
// key_edge_detect: registers the (already synchronised) continue key and
// produces a one-cycle press pulse on its rising edge. Shared by the stage
// controllers.
module key_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic key_next,
   output logic press
);

   logic key_q;

   // Previous key level; updated every cycle so a held key never repeats.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_q <= 1'b0;
      end else begin
         key_q <= key_next;
      end
   end

   assign press = key_next & ~key_q;

endmodule

// File: rtl/choose_ref_node_control.sv
// choose_ref_node_control: stage-4 control FSM for choosing the reference
// (ground) node. Drives the datapath through go_*/ld_* lines and reports
// completion on stage_done.
// Optional feature: define CHOOSE_REF_AUTO_ADVANCE_EN to let the CHOOSE and
// Ground prompts advance by themselves after HOLD_CYCLES idle-key cycles.
module choose_ref_node_control
   import choose_ref_node_control_pkg::*;
#(
   parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic key_next,
   input  logic data_reset_done,
   input  logic done_judge,
   input  logic node_index_valid,
   output logic go_reset_data,
   output logic go_display_choose,
   output logic go_display_refnode,
   output logic ld_node_index,
   output logic go_judge_valid,
   output logic go_display_invalid,
   output logic stage_done
);

   state_t state_reg;
   state_t state_next;
   logic   press;
   logic   hold_expired;
   logic   auto_advance;

   key_edge_detect u_key_edge_detect (
      .clk      (clk),
      .reset    (reset),
      .key_next (key_next),
      .press    (press)
   );

   // HOLD_CYCLES below 2 would let a prompt vanish on its entry cycle.
   if (HOLD_CYCLES < 2) begin : g_hold_cycles_too_small
   end

`ifdef CHOOSE_REF_AUTO_ADVANCE_EN
   localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

   logic [CW-1:0] hold_cnt;

   // Prompt dwell counter: runs in CHOOSE/REFNODE, saturates at the last
   // count while the key is held, and restarts on every state change.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt <= '0;
      end else if (state_next != state_reg) begin
         hold_cnt <= '0;
      end else if ((state_reg == ST_CHOOSE || state_reg == ST_REFNODE) &&
                   (hold_cnt != HOLD_LAST)) begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

   assign hold_expired = (hold_cnt == HOLD_LAST);
`else
   assign hold_expired = 1'b0;
`endif

   // A held key blocks auto-advance until it is released.
   assign auto_advance = hold_expired & ~key_next;

   // Next-state selection; start only matters in IDLE/DONE, press only in
   // the prompt and entry states.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE:    if (start) state_next = ST_RST;
         ST_RST:     if (data_reset_done) state_next = ST_CHOOSE;
         ST_CHOOSE:  if (press | auto_advance) state_next = ST_REFNODE;
         ST_REFNODE: if (press | auto_advance) state_next = ST_LOAD;
         ST_LOAD:    if (press) state_next = ST_JUDGE;
         ST_JUDGE: begin
            if (done_judge) begin
               state_next = node_index_valid ? ST_DONE : ST_INVALID;
            end
         end
         ST_INVALID: if (press) state_next = ST_LOAD;
         ST_DONE:    if (start) state_next = ST_RST;
         default:    state_next = ST_IDLE;
      endcase
   end

   // State register plus registered Moore outputs decoded from the state
   // being entered, so each line is high exactly while in its state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg          <= ST_IDLE;
         go_reset_data      <= 1'b0;
         go_display_choose  <= 1'b0;
         go_display_refnode <= 1'b0;
         ld_node_index      <= 1'b0;
         go_judge_valid     <= 1'b0;
         go_display_invalid <= 1'b0;
         stage_done         <= 1'b0;
      end else begin
         state_reg          <= state_next;
         go_reset_data      <= (state_next == ST_RST);
         go_display_choose  <= (state_next == ST_CHOOSE);
         go_display_refnode <= (state_next == ST_REFNODE);
         ld_node_index      <= (state_next == ST_LOAD);
         go_judge_valid     <= (state_next == ST_JUDGE);
         go_display_invalid <= (state_next == ST_INVALID);
         stage_done         <= (state_next == ST_DONE);
      end
   end

endmodule

// File: tb/tb_choose_ref_node_control.sv
// Directed bench for choose_ref_node_control. Inputs are driven and outputs
// sampled on the falling clock edge. Build with CHOOSE_REF_AUTO_ADVANCE_EN
// defined to exercise the prompt auto-advance sequence instead.
module tb_choose_ref_node_control;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic key_next = 1'b0;
   logic data_reset_done = 1'b0;
   logic done_judge = 1'b0;
   logic node_index_valid = 1'b0;
   logic go_reset_data;
   logic go_display_choose;
   logic go_display_refnode;
   logic ld_node_index;
   logic go_judge_valid;
   logic go_display_invalid;
   logic stage_done;

   int checks = 0;
   int errors = 0;
   int num_nodes = 4;
   int switches = 0;

   // Expected output vectors, order:
   // {go_reset_data, choose, refnode, ld_node_index, judge, invalid, stage_done}
   localparam logic [6:0] O_IDLE    = 7'b000_0000;
   localparam logic [6:0] O_RST     = 7'b100_0000;
   localparam logic [6:0] O_CHOOSE  = 7'b010_0000;
   localparam logic [6:0] O_REFNODE = 7'b001_0000;
   localparam logic [6:0] O_LOAD    = 7'b000_1000;
   localparam logic [6:0] O_JUDGE   = 7'b000_0100;
   localparam logic [6:0] O_INVALID = 7'b000_0010;
   localparam logic [6:0] O_DONE    = 7'b000_0001;

   always #5 clk = ~clk;

   choose_ref_node_control #(.HOLD_CYCLES(8)) dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .key_next           (key_next),
      .data_reset_done    (data_reset_done),
      .done_judge         (done_judge),
      .node_index_valid   (node_index_valid),
      .go_reset_data      (go_reset_data),
      .go_display_choose  (go_display_choose),
      .go_display_refnode (go_display_refnode),
      .ld_node_index      (ld_node_index),
      .go_judge_valid     (go_judge_valid),
      .go_display_invalid (go_display_invalid),
      .stage_done         (stage_done)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_outs(input string tag, input logic [6:0] expected);
      logic [6:0] observed;
      observed = {go_reset_data, go_display_choose, go_display_refnode,
                  ld_node_index, go_judge_valid, go_display_invalid, stage_done};
      checks++;
      assert (observed === expected) begin
         $display("check %0s outputs=%b ok", tag, observed);
      end else begin
         errors++;
         $error("FAIL %0s: outputs=%b required=%b", tag, observed, expected);
      end
   endtask

   // One clean key press: high for one edge, low for the next.
   task automatic press_key();
      key_next = 1'b1;
      step();
      key_next = 1'b0;
      step();
   endtask

   // Start from IDLE/DONE and walk through RST (datapath answers one edge
   // after sampling go_reset_data) into CHOOSE.
   task automatic start_to_choose(input string tag);
      start = 1'b1;
      step();
      start = 1'b0;
      done_judge = 1'b0;
      check_outs({tag, "_rst1"}, O_RST);
      step();
      check_outs({tag, "_rst2"}, O_RST);
      data_reset_done = 1'b1;
      step();
      data_reset_done = 1'b0;
      check_outs({tag, "_choose"}, O_CHOOSE);
   endtask

   // In JUDGE: datapath needs one edge to compare, then posts the result.
   task automatic judge(input string tag, input logic [6:0] expected);
      check_outs({tag, "_judge"}, O_JUDGE);
      step();
      check_outs({tag, "_judge_hold"}, O_JUDGE);
      done_judge = 1'b1;
      node_index_valid = (switches < num_nodes);
      step();
      check_outs({tag, "_result"}, expected);
   endtask

   initial begin
      @(negedge clk);
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      check_outs("reset", O_IDLE);
      step();
      check_outs("idle_hold", O_IDLE);

`ifdef CHOOSE_REF_AUTO_ADVANCE_EN
      start_to_choose("auto");
      for (int i = 2; i <= 8; i++) begin
         step();
         check_outs($sformatf("auto_choose_c%0d", i), O_CHOOSE);
      end
      step();
      check_outs("auto_refnode", O_REFNODE);
      for (int i = 2; i <= 8; i++) begin
         step();
         check_outs($sformatf("auto_refnode_c%0d", i), O_REFNODE);
      end
      step();
      check_outs("auto_load", O_LOAD);
      for (int i = 0; i < 20; i++) step();
      check_outs("auto_load_waits", O_LOAD);
      switches = 3;
      press_key();
      judge("auto", O_DONE);
`else
      // Bring-up: two RST cycles then CHOOSE.
      start_to_choose("s1");

      // Key held 10 cycles: a single advance.
      key_next = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check_outs($sformatf("held_c%0d", i), O_REFNODE);
      end
      key_next = 1'b0;
      step();
      check_outs("held_release", O_REFNODE);
      press_key();
      check_outs("to_load", O_LOAD);

      // Valid index 3 < 4.
      switches = 3;
      press_key();
      judge("valid3", O_DONE);
      step();
      check_outs("done_hold", O_DONE);
      press_key();
      check_outs("done_press_ignored", O_DONE);

      // press and start together in DONE: start wins.
      key_next = 1'b1;
      start_to_choose("restart");
      key_next = 1'b0;
      step();
      check_outs("restart_no_press", O_CHOOSE);

      // start ignored outside IDLE/DONE; no auto-advance in default build.
      start = 1'b1;
      step();
      start = 1'b0;
      check_outs("choose_start_ignored", O_CHOOSE);
      for (int i = 0; i < 20; i++) step();
      check_outs("choose_no_auto", O_CHOOSE);
      press_key();
      check_outs("r_refnode", O_REFNODE);
      press_key();
      check_outs("r_load", O_LOAD);

      // Invalid index 7 >= 4, retry with 2.
      switches = 7;
      press_key();
      judge("invalid7", O_INVALID);
      done_judge = 1'b0;
      step();
      check_outs("invalid_hold", O_INVALID);
      press_key();
      check_outs("retry_load", O_LOAD);
      switches = 2;
      press_key();
      judge("valid2", O_DONE);

      // Reset mid-JUDGE.
      start_to_choose("s3");
      press_key();
      press_key();
      done_judge = 1'b0;
      press_key();
      check_outs("s3_judge", O_JUDGE);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_outs("reset_in_judge", O_IDLE);
      press_key();
      check_outs("idle_press_ignored", O_IDLE);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/choose_ref_node_control.md
# choose_ref_node_control

Control FSM for the stage-4 "choose reference node" step. It sequences the choose-ref-node datapath through reset, the CHOOSE and Ground prompts, live node-index entry, range judgement and invalid-entry retry. It talks to the datapath only through the datapath's go/done handshake lines. It reports completion to the top-level stage sequencer through `stage_done`.

## Interface
Parameters:
- `HOLD_CYCLES`, default 50_000_000, prompt auto-advance interval in clk cycles (1 s at 50 MHz); used only when the macro is defined; must be ≥ 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  in  1  one-cycle pulse from the stage sequencer; begins or restarts the stage.
- `key_next`  in  1  continue key, level, active-high, already synchronised.
- `data_reset_done`  in  1  datapath: reset completed.
- `done_judge`  in  1  datapath: judgement result available (sticky).
- `node_index_valid`  in  1  datapath: entered index < numNodes.
- `go_reset_data`  out  1  datapath: clear ground_node and judge flags.
- `go_display_choose`  out  1  datapath: show "CHOOSE".
- `go_display_refnode`  out  1  datapath: show "Ground".
- `ld_node_index`  out  1  datapath: track switches into ground_node, show "nOdE xx".
- `go_judge_valid`  out  1  datapath: compare ground_node against numNodes.
- `go_display_invalid`  out  1  datapath: show "InUALd", clear done_judge.
- `stage_done`  out  1  level: valid ground node latched.

## Operation
- States: IDLE, RST, CHOOSE, REFNODE, LOAD, JUDGE, INVALID, DONE.
- Moore outputs: decoded only from the registered state; each go_* is high in exactly one state.
  - RST → `go_reset_data`
  - CHOOSE → `go_display_choose`
  - REFNODE → `go_display_refnode`
  - LOAD → `ld_node_index`
  - JUDGE → `go_judge_valid`
  - INVALID → `go_display_invalid`
  - DONE → `stage_done`
- `press` = `key_next & ~key_q`, where `key_q` is `key_next` registered.
  - Only a rising edge advances the FSM. A held key never advances more than once.
- Transitions:
  - IDLE: `start` → RST.
  - RST: `data_reset_done` → CHOOSE; otherwise stay.
  - CHOOSE: `press` → REFNODE.
  - REFNODE: `press` → LOAD.
  - LOAD: `press` → JUDGE. ground_node keeps the switch value sampled on the last LOAD cycle.
  - JUDGE: when `done_judge`, go to DONE if `node_index_valid`, otherwise to INVALID; while `done_judge`=0, stay.
  - INVALID: `press` → LOAD.
  - DONE: `start` → RST; otherwise hold.
- `start` is ignored in every state except IDLE and DONE.
- `press` is ignored in IDLE, RST, JUDGE and DONE.
- `key_q` updates in every state, so a key already held when a state is entered does not count as a press.

## Timing
- On `reset`: state = IDLE, `key_q` = 0, hold counter = 0, and every output = 0. Reset is valid mid-stage and takes priority over all inputs.
- State entry lags the qualifying input by 1 cycle. The go_* line is high from the entry cycle, and the datapath acts on the first clock edge inside the state.
- RST lasts at least 2 cycles: `data_reset_done` rises one edge after `go_reset_data` is sampled.
- JUDGE lasts at least 2 cycles. `done_judge` was cleared by RST or INVALID, so a stale result cannot be consumed.
- INVALID lasts at least 1 cycle, which guarantees `done_judge` is cleared before the next JUDGE.
- `press` and `start` in the same DONE cycle: `start` wins.
- No timeout in RST or JUDGE. The datapath always responds within 1 cycle.

## Configuration
- `CHOOSE_REF_AUTO_ADVANCE_EN`:
  - Defined: a hold counter runs in CHOOSE and REFNODE and clears on every state change. When it reaches `HOLD_CYCLES`-1 and `key_next`=0, the FSM advances as if pressed. If the key is held, it waits for release.
  - Undefined: the counter is not built, and CHOOSE and REFNODE advance only on `press`.
- LOAD and INVALID always require `press`.

## Structure
- Shared stage-4 package holds:
  - the state encoding constants (3 bits, IDLE = 0);
  - the default `HOLD_CYCLES`.
- One natural sub-module, `key_edge_detect`: holds the `key_q` register and produces the `press` pulse. It is reused by the other stage controllers.
- Counter width = $clog2(HOLD_CYCLES).

## Test plan
- Reset then `start`: `go_reset_data` high 2 cycles, then `go_display_choose` high; no other go_* high.
- `key_next` held high for 10 cycles in CHOOSE → exactly one advance, to REFNODE; a second press → LOAD with `ld_node_index`=1.
- numNodes=4, switches=3, press in LOAD → JUDGE → `stage_done`=1 within 3 cycles and held; `start` → RST.
- numNodes=4, switches=7 → INVALID (`go_display_invalid`=1); press → LOAD; switches=2, press → DONE.
- `reset` asserted in JUDGE → next cycle IDLE, all outputs 0; `press` in IDLE → no change.
- Macro defined, `HOLD_CYCLES`=8, key idle: CHOOSE→REFNODE after 8 cycles, REFNODE→LOAD after 8 more; LOAD still waits for `press`.
